// File: rtl/arm_dp_pkg.sv
// Shared types and constants for the ARM data-processing encoder and its datapath.
package arm_dp_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned ROT_W  = 4;
  localparam int unsigned IMM8_W = 8;

  localparam logic [3:0] COND_AL = 4'hE;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    OUT    = 2'd2,
    ERR    = 2'd3
  } state_e;

  // Request fields kept for the duration of an immediate search.
  typedef struct packed {
    logic [REG_W-1:0]  cmd;
    logic [REG_W-1:0]  rn;
    logic [REG_W-1:0]  rd;
    logic [WORD_W-1:0] imm;
  } req_t;

  function automatic logic [WORD_W-1:0] encode_dp(input logic             i,
                                                  input logic [REG_W-1:0] cmd,
                                                  input logic [REG_W-1:0] rn,
                                                  input logic [REG_W-1:0] rd,
                                                  input logic [11:0]      op2);
    return {COND_AL, 2'b00, i, cmd, 1'b0, rn, rd, op2};
  endfunction

endpackage

// File: rtl/arm_dp_encoder_if.sv
// Request/response bus between an instruction requester and arm_dp_encoder.
interface arm_dp_encoder_if;
  import arm_dp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_I;
  logic [REG_W-1:0]  in_cmd;
  logic [REG_W-1:0]  in_Rn;
  logic [REG_W-1:0]  in_Rd;
  logic [REG_W-1:0]  in_Rm;
  logic [WORD_W-1:0] in_imm32;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] Instr;
  logic              err;

  modport master (
    output in_valid, in_I, in_cmd, in_Rn, in_Rd, in_Rm, in_imm32, out_ready,
    input  in_ready, out_valid, Instr, err
  );

  modport slave (
    input  in_valid, in_I, in_cmd, in_Rn, in_Rd, in_Rm, in_imm32, out_ready,
    output in_ready, out_valid, Instr, err
  );

endinterface

// File: rtl/imm_rot_check.sv
// Tests one rotation: hit when imm32 ROL 2r fits in eight bits.
module imm_rot_check
  import arm_dp_pkg::*;
(
  input  logic [WORD_W-1:0] imm32,
  input  logic [ROT_W-1:0]  r,
  output logic              hit,
  output logic [IMM8_W-1:0] imm8
);

  logic [5:0]        sh;
  logic [WORD_W-1:0] rotated;

  // A right shift by 32 yields zero, so r=0 needs no special case.
  always_comb begin
    sh      = 6'({r, 1'b0});
    rotated = (imm32 << sh) | (imm32 >> (6'd32 - sh));
    hit     = (rotated[WORD_W-1:IMM8_W] == '0);
    imm8    = rotated[IMM8_W-1:0];
  end

endmodule

// File: rtl/arm_dp_encoder.sv
// Builds ARM data-processing words, searching for the canonical rotated immediate.
module arm_dp_encoder
  import arm_dp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  arm_dp_encoder_if.slave   bus
);

  state_e             state_q, state_d;
  req_t               req_q, req_d;
  logic [ROT_W-1:0]   r_q, r_d;
  logic [WORD_W-1:0]  instr_q, instr_d;
  logic               out_valid_q, out_valid_d;
  logic               err_q, err_d;
  logic               in_ready_q, in_ready_d;

  logic               hit;
  logic [IMM8_W-1:0]  imm8;

  imm_rot_check u_imm_rot_check (
    .imm32 (req_q.imm),
    .r     (r_q),
    .hit   (hit),
    .imm8  (imm8)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= '0;
      r_q         <= '0;
      instr_q     <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      r_q         <= r_d;
      instr_q     <= instr_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next state; handshake flags are decoded from the next state so they stay registered.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    r_d     = r_q;
    instr_d = instr_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          req_d = '{cmd: bus.in_cmd, rn: bus.in_Rn, rd: bus.in_Rd, imm: bus.in_imm32};
          r_d   = '0;
          if (bus.in_I) begin
            state_d = SEARCH;
          end else begin
            state_d = OUT;
            instr_d = encode_dp(1'b0, bus.in_cmd, bus.in_Rn, bus.in_Rd,
                                {8'h00, bus.in_Rm});
          end
        end
      end
      SEARCH: begin
        if (hit) begin
          state_d = OUT;
          instr_d = encode_dp(1'b1, req_q.cmd, req_q.rn, req_q.rd, {r_q, imm8});
        end else if (r_q == 4'hF) begin
          state_d = ERR;
        end else begin
          r_d = 4'(r_q + 4'd1);
        end
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == OUT);
    err_d       = (state_d == ERR);
    in_ready_d  = (state_d == IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Instr     = instr_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_arm_dp_encoder.sv
// Scoreboard bench for arm_dp_encoder: directed requests, decoupled output monitor.
module tb_arm_dp_encoder;
  import arm_dp_pkg::*;

  typedef struct {
    bit          is_err;
    logic [31:0] instr;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  arm_dp_encoder_if bus();

  arm_dp_encoder u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per new output presentation or error pulse.
  bit          held = 1'b0;
  logic [31:0] held_instr = '0;
  bit          prev_err = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (prev_err) begin
      chk("post_err_ready", 32'(bus.in_ready), 32'd1);
      chk("err_one_cycle", 32'(bus.err), 32'd0);
    end
    if (bus.out_valid) begin
      if (held) begin
        chk("instr_stable", bus.Instr, held_instr);
      end else if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("kind_is_instr", 32'(e.is_err), 32'd0);
        chk("instr", bus.Instr, e.instr);
        chk("out_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        held_instr = bus.Instr;
      end
      held = !bus.out_ready;
    end else begin
      held = 1'b0;
    end
    if (bus.err && !prev_err) begin
      if (sb.size() == 0) begin
        chk("unexpected_err", 32'(bus.err), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("kind_is_err", 32'(e.is_err), 32'd1);
        chk("err_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        chk("err_no_valid", 32'(bus.out_valid), 32'd0);
      end
    end
    prev_err = bus.err;
  end

  task automatic send(input logic i, input logic [3:0] cmd, input logic [3:0] rn,
                      input logic [3:0] rd, input logic [3:0] rm, input logic [31:0] imm,
                      input bit is_err, input logic [31:0] exp_instr, input int lat,
                      input bit push);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_I     = i;
    bus.in_cmd   = cmd;
    bus.in_Rn    = rn;
    bus.in_Rd    = rd;
    bus.in_Rm    = rm;
    bus.in_imm32 = imm;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_I     = ~i;
    bus.in_cmd   = ~cmd;
    bus.in_Rn    = ~rn;
    bus.in_Rd    = ~rd;
    bus.in_Rm    = ~rm;
    bus.in_imm32 = 32'h1234_5678;
    if (push) begin
      e.is_err = is_err;
      e.instr  = exp_instr;
      e.lat    = lat;
      e.acc    = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_I      = 1'b0;
    bus.in_cmd    = '0;
    bus.in_Rn     = '0;
    bus.in_Rd     = '0;
    bus.in_Rm     = '0;
    bus.in_imm32  = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_instr", bus.Instr, 32'h0);

    // ADD R3,R1,R2
    send(1'b0, OP_ADD, 4'd1, 4'd3, 4'd2, 32'h0, 1'b0, 32'hE0813002, 1, 1'b1);
    drain();
    // ADD R1,R2,#0xFF
    send(1'b1, OP_ADD, 4'd2, 4'd1, 4'd0, 32'h0000_00FF, 1'b0, 32'hE28210FF, 2, 1'b1);
    drain();
    // MOV R0,#0xFF000000 -> rot=4
    send(1'b1, OP_MOV, 4'd0, 4'd0, 4'd0, 32'hFF00_0000, 1'b0, 32'hE3A004FF, 6, 1'b1);
    drain();
    // ORR R6,R5,#0 -> rot=0, imm8=0
    send(1'b1, OP_ORR, 4'd5, 4'd6, 4'd0, 32'h0, 1'b0, 32'hE3856000, 2, 1'b1);
    drain();
    // MOV R2,#0x40000000: several r hit, smallest is r=1
    send(1'b1, OP_MOV, 4'd0, 4'd2, 4'd0, 32'h4000_0000, 1'b0, 32'hE3A02101, 3, 1'b1);
    drain();
    // AND R7,R8,#0x3FC: only r=15 hits
    send(1'b1, OP_AND, 4'd8, 4'd7, 4'd0, 32'h0000_03FC, 1'b0, 32'hE2087FFF, 17, 1'b1);
    drain();
    // Unencodable immediate
    send(1'b1, OP_MOV, 4'd0, 4'd1, 4'd0, 32'h0000_0101, 1'b1, 32'h0, 17, 1'b1);
    drain();

    // Back-pressure: SUB R4,R5,R6 held for five cycles
    bus.out_ready = 1'b0;
    send(1'b0, OP_SUB, 4'd5, 4'd4, 4'd6, 32'h0, 1'b0, 32'hE0454006, 1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset during SEARCH aborts silently
    send(1'b1, OP_MOV, 4'd0, 4'd0, 4'd0, 32'hFF00_0000, 1'b0, 32'h0, 0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_err", 32'(bus.err), 32'd0);
    chk("abort_instr", bus.Instr, 32'h0);
    repeat (20) @(negedge clk);
    send(1'b1, OP_MOV, 4'd0, 4'd0, 4'd0, 32'hFF00_0000, 1'b0, 32'hE3A004FF, 6, 1'b1);
    drain();

    // Reset wins over a same-edge handshake
    @(negedge clk);
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_I      = 1'b0;
    bus.in_cmd    = OP_ADD;
    bus.in_Rn     = 4'd1;
    bus.in_Rd     = 4'd2;
    bus.in_Rm     = 4'd3;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_hs_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_hs_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_hs_instr", bus.Instr, 32'h0);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arm_dp_encoder.md
ARM_DP_ENCODER -- requirements
Module: arm_dp_encoder

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high, on the ports clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request fields valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 in_I  input  1  0 selects register operand, 1 selects immediate operand.
REQ-007 in_cmd  input  4  data-processing opcode, copied to Instr[24:21].
REQ-008 in_Rn / in_Rd / in_Rm  input  4 each  register numbers; in_Rm is ignored when in_I=1.
REQ-009 in_imm32  input  32  requested immediate value; ignored when in_I=0.
REQ-010 out_valid  output  1  Instr holds a complete encoding.
REQ-011 out_ready  input  1  datapath consumes Instr.
REQ-012 Instr  output  32  encoded ARM data-processing word.
REQ-013 err  output  1  one-cycle pulse: in_imm32 cannot be encoded.

Function
REQ-014 Encoding SHALL be: [31:28]=4'hE, [27:26]=00, [25]=I, [24:21]=cmd, [20]=0, [19:16]=Rn, [15:12]=Rd.
REQ-015 [11:0] SHALL be {8'h00,Rm} when I=0, and {rot[3:0],imm8[7:0]} when I=1.
REQ-016 The immediate field SHALL satisfy imm8 ROR (2*rot) == in_imm32; this is the inverse of the datapath extend rule.
REQ-017 The FSM SHALL have the states IDLE, SEARCH, OUT and ERR.
REQ-018 in_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where in_valid and in_ready are both 1, and all fields are registered on that edge.
REQ-019 On acceptance with I=0, the FSM SHALL go IDLE->OUT, so out_valid rises on the cycle after acceptance.
REQ-020 On acceptance with I=1, the FSM SHALL go IDLE->SEARCH with the counter r=0.
REQ-021 In SEARCH, each cycle SHALL test one value of r: hit when (imm ROL 2r)[31:8]==0.
REQ-022 On a hit, the block SHALL latch rot=r and imm8=(imm ROL 2r)[7:0] and go to OUT.
REQ-023 On a miss, the block SHALL increment r.
REQ-024 The smallest hitting r SHALL win, giving a unique canonical encoding.
REQ-025 Latency for I=1: with a hit at r=k, out_valid SHALL rise k+2 cycles after the acceptance edge.
REQ-026 If there is a miss at r=15, the FSM SHALL go SEARCH->ERR; ERR lasts exactly one cycle with err=1 and out_valid=0, then returns to IDLE.
REQ-027 No partial Instr SHALL be emitted on the error path.
REQ-028 In OUT: out_valid=1, and Instr SHALL be held stable until an edge where out_ready=1.
REQ-029 After that edge the FSM SHALL return to IDLE, giving at most one request every 2 cycles in register form.
REQ-030 out_ready SHALL be ignored outside OUT.
REQ-031 in_valid SHALL be ignored outside IDLE; fields changing mid-operation SHALL have no effect.
REQ-032 in_imm32=0 SHALL encode as rot=0, imm8=0 at r=0.

Reset
REQ-033 On reset: state=IDLE, r=0, out_valid=0, err=0, Instr=32'h0, and in_ready=1 on the first cycle after reset deasserts.
REQ-034 Reset during SEARCH, OUT or ERR SHALL abort the operation with no err pulse and no out_valid.
REQ-035 Reset SHALL take priority over every other event, including a same-edge handshake.

Structure
REQ-036 A shared package arm_dp_pkg SHALL hold the FSM state enum, COND_AL=4'hE, and the opcode constants (AND=0000, SUB=0010, ADD=0100, ORR=1100, MOV=1101); the datapath and its bench use the same package.
REQ-037 One combinational sub-module imm_rot_check (inputs imm32 and r; outputs hit and imm8) SHALL perform the per-cycle test.
REQ-038 The encoding mux, FSM and registers SHALL stay in arm_dp_encoder.

Verification
REQ-039 ADD R3,R1,R2 (I=0, cmd=0100, Rn=1, Rd=3, Rm=2) -> Instr=0xE0813002, out_valid 1 cycle after acceptance.
REQ-040 ADD R1,R2,#0xFF (I=1) -> Instr=0xE28210FF with rot=0, out_valid 2 cycles after acceptance.
REQ-041 MOV R0,#0xFF000000 (cmd=1101, Rn=0) -> rot=4, Instr=0xE3A004FF, out_valid 6 cycles after acceptance; feeding Instr to the datapath yields ALUResult=0xFF000000.
REQ-042 in_imm32=0x00000101 -> err high for exactly one cycle, 17 cycles after acceptance; out_valid never rises; in_ready is 1 on the next cycle.
REQ-043 Hold out_ready=0 for 5 cycles in OUT -> Instr and out_valid stable, in_ready=0; release -> IDLE on the next edge.
REQ-044 Assert reset during SEARCH for in_imm32=0xFF000000 -> next cycle IDLE, out_valid=0, err=0, Instr=0; a fresh request then encodes correctly.
